jedro_1_decoder: RTL and testbench

//  Decode stage directly upstream of jedro_1_alu. Accepts 32-bit RV32I instructions over a

---
 rtl/jedro_1_decoder.sv | 192 +++++++++++++++++++
 tb/tb_jedro_1_decoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_decoder.sv
// ---------------------------------------------------------------------------
// jedro_1_decoder
//   Decode stage that feeds jedro_1_alu. It takes RV32I instructions over a
//   valid/ready handshake, decodes OP, OP-IMM and LUI, reads operands from the
//   register file (or forwards them from the ALU result register) and loads
//   the ALU-stage registers. If an instruction reads the register written by
//   the instruction issued just before it, the decoder stalls for one cycle.
//   An illegal encoding sets a sticky flag and halts the decoder until reset.
//
// Ports
//   clk_i            clock
//   rstn_i           synchronous active-low reset
//   instr_i          instruction word
//   instr_valid_i    instr_i is valid
//   instr_ready_o    instruction is accepted this cycle (combinational)
//   rf_rs1_addr_o    regfile read address 1 (instr_i[19:15])
//   rf_rs2_addr_o    regfile read address 2 (instr_i[24:20])
//   rf_rs1_data_i    regfile read data 1 (asynchronous read)
//   rf_rs2_data_i    regfile read data 2
//   alu_res_i        ALU result register (forwarding source)
//   alu_dest_addr_i  ALU destination register
//   alu_wb_i         ALU write-back enable
//   alu_sel_ro       registered ALU select {b3, funct3}
//   op_a_ro          registered operand A
//   op_b_ro          registered operand B
//   dest_addr_ro     registered destination register
//   wb_ro            registered write-back enable
//   illegal_instr_ro sticky illegal-instruction flag
// ---------------------------------------------------------------------------
module jedro_1_decoder #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [DATA_WIDTH-1:0]     instr_i,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr_o,
    input  logic [DATA_WIDTH-1:0]     rf_rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rf_rs2_data_i,
    input  logic [DATA_WIDTH-1:0]     alu_res_i,
    input  logic [REG_ADDR_WIDTH-1:0] alu_dest_addr_i,
    input  logic                      alu_wb_i,
    output logic [ALU_OP_WIDTH-1:0]   alu_sel_ro,
    output logic [DATA_WIDTH-1:0]     op_a_ro,
    output logic [DATA_WIDTH-1:0]     op_b_ro,
    output logic [REG_ADDR_WIDTH-1:0] dest_addr_ro,
    output logic                      wb_ro,
    output logic                      illegal_instr_ro
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // x0 reads as zero; otherwise the ALU result register wins over the
    // register file because the regfile has not been written with it yet.
    function automatic logic [DATA_WIDTH-1:0] read_operand(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]     rf_data,
        input logic [DATA_WIDTH-1:0]     fwd_data,
        input logic [REG_ADDR_WIDTH-1:0] fwd_addr,
        input logic                      fwd_en
    );
        if (rs == '0)
            return '0;
        else if (fwd_en && (rs == fwd_addr))
            return fwd_data;
        else
            return rf_data;
    endfunction

    logic [0:0]                state_q;
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    assign rf_rs1_addr_o = rs1;
    assign rf_rs2_addr_o = rs2;

    logic signed [DATA_WIDTH-1:0] imm_i_sext;
    logic        [DATA_WIDTH-1:0] imm_u;
    logic        [DATA_WIDTH-1:0] rs1_val;
    logic        [DATA_WIDTH-1:0] rs2_val;

    assign imm_i_sext = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_u      = {instr_i[31:12], 12'b0};
    assign rs1_val    = read_operand(rs1, rf_rs1_data_i, alu_res_i, alu_dest_addr_i, alu_wb_i);
    assign rs2_val    = read_operand(rs2, rf_rs2_data_i, alu_res_i, alu_dest_addr_i, alu_wb_i);

    logic                    legal;
    logic                    use_rs1;
    logic                    use_rs2;
    logic [ALU_OP_WIDTH-1:0] sel_d;
    logic [DATA_WIDTH-1:0]   op_a_d;
    logic [DATA_WIDTH-1:0]   op_b_d;

    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        sel_d   = '0;
        op_a_d  = rs1_val;
        op_b_d  = rs2_val;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                sel_d   = {instr_i[30], funct3};
                // funct7 0x20 only selects SUB and SRA
                legal   = (funct7 == 7'h00) ||
                          ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                op_b_d  = imm_i_sext;
                // only SRAI uses bit 30; ADDI etc. carry it as immediate data
                sel_d   = {(funct3 == 3'b101) && instr_i[30], funct3};
                case (funct3)
                    3'b001:  legal = (funct7 == 7'h00);
                    3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    default: legal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                legal  = 1'b1;
                op_a_d = '0;
                op_b_d = imm_u;
            end
            default: ;
        endcase
    end

    // The previous instruction is still in our output registers, so its
    // result is not visible on the ALU forward path until the next cycle.
    logic hazard;
    logic accept;

    assign hazard = wb_ro && (
                    (use_rs1 && (rs1 != '0) && (rs1 == dest_addr_ro)) ||
                    (use_rs2 && (rs2 != '0) && (rs2 == dest_addr_ro)));

    assign instr_ready_o = (state_q == ST_RUN) && !hazard;
    assign accept        = instr_valid_i && instr_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q          <= ST_RUN;
            alu_sel_ro       <= '0;
            op_a_ro          <= '0;
            op_b_ro          <= '0;
            dest_addr_ro     <= '0;
            wb_ro            <= 1'b0;
            illegal_instr_ro <= 1'b0;
        end else begin
            if (accept && legal) begin
                alu_sel_ro   <= sel_d;
                op_a_ro      <= op_a_d;
                op_b_ro      <= op_b_d;
                dest_addr_ro <= rd;
                wb_ro        <= (rd != '0);
            end else begin
                alu_sel_ro   <= '0;
                op_a_ro      <= '0;
                op_b_ro      <= '0;
                dest_addr_ro <= '0;
                wb_ro        <= 1'b0;
            end
            if (accept && !legal) begin
                illegal_instr_ro <= 1'b1;
                state_q          <= ST_HALT;
            end
        end
    end

endmodule

// File: tb/tb_jedro_1_decoder.sv
module tb_jedro_1_decoder;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        valid = 1'b0;
    logic        ready;
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rs1d, rs2d;
    logic [31:0] alu_res  = 32'd0;
    logic [4:0]  alu_dest = 5'd0;
    logic        alu_wb   = 1'b0;
    logic [3:0]  sel;
    logic [31:0] op_a, op_b;
    logic [4:0]  dest;
    logic        wb, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jedro_1_decoder dut (
        .clk_i(clk), .rstn_i(rstn),
        .instr_i(instr), .instr_valid_i(valid), .instr_ready_o(ready),
        .rf_rs1_addr_o(rs1a), .rf_rs2_addr_o(rs2a),
        .rf_rs1_data_i(rs1d), .rf_rs2_data_i(rs2d),
        .alu_res_i(alu_res), .alu_dest_addr_i(alu_dest), .alu_wb_i(alu_wb),
        .alu_sel_ro(sel), .op_a_ro(op_a), .op_b_ro(op_b),
        .dest_addr_ro(dest), .wb_ro(wb), .illegal_instr_ro(illegal)
    );

    // x0 holds garbage in the regfile model: the decoder must never use it
    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'hDEADBEEF;
        if (i == 4) return 32'd10;
        if (i == 5) return 32'd3;
        if (i == 7) return 32'hFFFFFFC0;
        return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] alu_fn(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            4'h0: return a + b;
            4'h8: return a - b;
            4'h1: return a << b[4:0];
            4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3: return (a < b) ? 32'd1 : 32'd0;
            4'h4: return a ^ b;
            4'h5: return a >> b[4:0];
            4'hD: return 32'($signed(a) >>> b[4:0]);
            4'h6: return a | b;
            4'h7: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                           input logic [2:0] f3, input logic [4:0] d);
        return {f7, r2, r1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] r1,
                                           input logic [2:0] f3, input logic [4:0] d);
        return {imm, r1, f3, d, 7'b0010011};
    endfunction

    function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] d);
        return {imm, d, 7'b0110111};
    endfunction

    // Environment: ALU stage register plus a regfile written one edge later
    logic [31:0] rf [32];
    logic        rf_loaded = 1'b0;

    assign rs1d = rf[rs1a];
    assign rs2d = rf[rs2a];

    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
            rf_loaded <= 1'b1;
        end else if (alu_wb) begin
            rf[alu_dest] <= alu_res;
        end
        alu_res  <= alu_fn(sel, op_a, op_b);
        alu_dest <= dest;
        alu_wb   <= wb;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: an in-order executor holding architectural register
    // values; what it expects on the outputs is what the instruction means.
    logic [31:0] arch [32];
    logic [3:0]  e_sel  = 4'd0;
    logic [31:0] e_a    = 32'd0, e_b = 32'd0;
    logic [4:0]  e_dest = 5'd0;
    logic        e_wb   = 1'b0, e_ill = 1'b0;
    logic        m_halt = 1'b0, armed = 1'b0, m_acc = 1'b0, e_ready;
    logic [6:0]  m_opc, m_f7;
    logic [2:0]  m_f3;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic        m_legal, m_u1, m_u2, m_haz;
    logic [3:0]  m_sel;
    logic [31:0] m_a, m_b;

    always @(negedge clk) begin
        if (armed) begin
            chk("sel",     32'(sel),     32'(e_sel));
            chk("op_a",    op_a,         e_a);
            chk("op_b",    op_b,         e_b);
            chk("dest",    32'(dest),    32'(e_dest));
            chk("wb",      32'(wb),      32'(e_wb));
            chk("illegal", 32'(illegal), 32'(e_ill));
        end
        m_opc = instr[6:0];  m_rd  = instr[11:7];  m_f3 = instr[14:12];
        m_rs1 = instr[19:15]; m_rs2 = instr[24:20]; m_f7 = instr[31:25];
        m_legal = 1'b0; m_u1 = 1'b0; m_u2 = 1'b0; m_sel = 4'd0;
        m_a = 32'd0; m_b = 32'd0;
        if (m_opc == 7'h33) begin
            m_u1 = 1'b1; m_u2 = 1'b1;
            m_legal = (m_f7 == 7'h00) || (m_f7 == 7'h20 && (m_f3 == 3'd0 || m_f3 == 3'd5));
            m_sel = {instr[30], m_f3};
            m_a = (m_rs1 == 5'd0) ? 32'd0 : arch[m_rs1];
            m_b = (m_rs2 == 5'd0) ? 32'd0 : arch[m_rs2];
        end else if (m_opc == 7'h13) begin
            m_u1 = 1'b1;
            if (m_f3 == 3'd1)      m_legal = (m_f7 == 7'h00);
            else if (m_f3 == 3'd5) m_legal = (m_f7 == 7'h00) || (m_f7 == 7'h20);
            else                   m_legal = 1'b1;
            m_sel = {(m_f3 == 3'd5) ? instr[30] : 1'b0, m_f3};
            m_a = (m_rs1 == 5'd0) ? 32'd0 : arch[m_rs1];
            m_b = 32'($signed(instr[31:20]));
        end else if (m_opc == 7'h37) begin
            m_legal = 1'b1;
            m_b = {instr[31:12], 12'd0};
        end
        m_haz = e_wb && ((m_u1 && m_rs1 != 5'd0 && m_rs1 == e_dest) ||
                         (m_u2 && m_rs2 != 5'd0 && m_rs2 == e_dest));
        e_ready = !m_halt && !m_haz;
        if (armed) begin
            chk("ready",    32'(ready), 32'(e_ready));
            chk("rs1_addr", 32'(rs1a),  32'(m_rs1));
            chk("rs2_addr", 32'(rs2a),  32'(m_rs2));
        end
        m_acc = 1'b0;
        if (!rstn) begin
            if (!armed) for (int i = 0; i < 32; i++) arch[i] = (i == 0) ? 32'd0 : init_val(i);
            armed = 1'b1; m_halt = 1'b0;
            e_sel = 4'd0; e_a = 32'd0; e_b = 32'd0; e_dest = 5'd0; e_wb = 1'b0; e_ill = 1'b0;
        end else if (armed) begin
            m_acc = valid && e_ready;
            if (m_acc && m_legal) begin
                e_sel = m_sel; e_a = m_a; e_b = m_b; e_dest = m_rd; e_wb = (m_rd != 5'd0);
                if (m_rd != 5'd0) arch[m_rd] = alu_fn(m_sel, m_a, m_b);
            end else begin
                e_sel = 4'd0; e_a = 32'd0; e_b = 32'd0; e_dest = 5'd0; e_wb = 1'b0;
                if (m_acc) begin e_ill = 1'b1; m_halt = 1'b1; end
            end
        end
    end

    task automatic step(input logic [31:0] ins, input logic v, input logic r);
        @(posedge clk);
        #1;
        instr = ins; valid = v; rstn = r;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        int         k   = int'($urandom % 32);
        logic [4:0] d   = 5'($urandom % 8);
        logic [4:0] r1  = 5'($urandom % 8);
        logic [4:0] r2  = 5'($urandom % 8);
        logic [2:0] f3  = 3'($urandom);
        logic [11:0] imm = 12'($urandom);
        logic [6:0] f7;
        if (k < 12) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && ($urandom % 2 == 0)) ? 7'h20 : 7'h00;
            return r_type(f7, r2, r1, f3, d);
        end else if (k < 24) begin
            if (f3 == 3'd1) imm[11:5] = 7'h00;
            else if (f3 == 3'd5) imm[11:5] = ($urandom % 2 == 0) ? 7'h20 : 7'h00;
            return i_type(imm, r1, f3, d);
        end else if (k < 29) begin
            return u_type(20'($urandom), d);
        end else if (k == 29) begin
            return r_type(7'($urandom), r2, r1, f3, d);
        end else if (k == 30) begin
            return i_type(imm, r1, ($urandom % 2 == 0) ? 3'd1 : 3'd5, d);
        end
        return $urandom;
    endfunction

    initial begin
        step(32'd0, 1'b0, 1'b0);
        step(32'd0, 1'b0, 1'b0);
        step(32'd0, 1'b0, 1'b1);
        chk("reset_wb",      32'(wb),      32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_op_a",    op_a,         32'd0);
        chk("reset_ready",   32'(ready),   32'd1);

        // ADDI x1,x0,5 ; ADD x2,x1,x1 -> one stall then forward
        step(i_type(12'd5, 5'd0, 3'd0, 5'd1), 1'b1, 1'b1);
        chk("t1_ready0", 32'(ready), 32'd1);
        step(r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 1'b1, 1'b1);
        chk("t1_addi_b",    op_b,         32'd5);
        chk("t1_addi_dest", 32'(dest),    32'd1);
        chk("t1_stall",     32'(ready),   32'd0);
        step(r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 1'b1, 1'b1);
        chk("t1_bubble_wb", 32'(wb),      32'd0);
        chk("t1_ready1",    32'(ready),   32'd1);
        step(32'd0, 1'b0, 1'b1);
        chk("t1_fwd_a", op_a,      32'd5);
        chk("t1_fwd_b", op_b,      32'd5);
        chk("t1_dest",  32'(dest), 32'd2);

        // SUB x3,x4,x5
        step(r_type(7'h20, 5'd5, 5'd4, 3'd0, 5'd3), 1'b1, 1'b1);
        step(32'd0, 1'b0, 1'b1);
        chk("t2_sel",  32'(sel),  32'h8);
        chk("t2_a",    op_a,      32'd10);
        chk("t2_b",    op_b,      32'd3);
        chk("t2_dest", 32'(dest), 32'd3);
        chk("t2_wb",   32'(wb),   32'd1);

        // LUI x8,0xABCDE
        step(u_type(20'hABCDE, 5'd8), 1'b1, 1'b1);
        step(32'd0, 1'b0, 1'b1);
        chk("t4_a",   op_a,     32'd0);
        chk("t4_b",   op_b,     32'hABCDE000);
        chk("t4_sel", 32'(sel), 32'h0);

        // ADDI x0,x1,1 ; ADD x9,x0,x0
        step(i_type(12'd1, 5'd1, 3'd0, 5'd0), 1'b1, 1'b1);
        step(32'd0, 1'b0, 1'b1);
        chk("t5_x0_wb", 32'(wb), 32'd0);
        step(r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd9), 1'b1, 1'b1);
        step(32'd0, 1'b0, 1'b1);
        chk("t5_a",  op_a,    32'd0);
        chk("t5_b",  op_b,    32'd0);
        chk("t5_wb", 32'(wb), 32'd1);

        // SRAI x6,x7,4 then an illegal SLLI
        step(i_type(12'h404, 5'd7, 3'd5, 5'd6), 1'b1, 1'b1);
        step(32'd0, 1'b0, 1'b1);
        chk("t3_sel",   32'(sel),        32'hD);
        chk("t3_shamt", op_b & 32'h1F,   32'd4);
        chk("t3_a",     op_a,            32'hFFFFFFC0);
        step(i_type(12'h401, 5'd1, 3'd1, 5'd10), 1'b1, 1'b1);
        chk("t3_bad_ready", 32'(ready), 32'd1);
        step(i_type(12'd1, 5'd0, 3'd0, 5'd1), 1'b1, 1'b1);
        chk("t3_illegal", 32'(illegal), 32'd1);
        chk("t3_halt_wb", 32'(wb),      32'd0);
        chk("t3_halt_rdy", 32'(ready),  32'd0);

        // reset in HALT
        step(i_type(12'd1, 5'd0, 3'd0, 5'd1), 1'b1, 1'b0);
        chk("t6_halt_rdy", 32'(ready), 32'd0);
        step(i_type(12'd1, 5'd0, 3'd0, 5'd1), 1'b1, 1'b1);
        chk("t6_ill_clr", 32'(illegal), 32'd0);
        chk("t6_dest",    32'(dest),    32'd0);
        chk("t6_ready",   32'(ready),   32'd1);

        // reset during a hazard stall
        step(i_type(12'd7, 5'd0, 3'd0, 5'd11), 1'b1, 1'b1);
        step(r_type(7'h00, 5'd0, 5'd11, 3'd0, 5'd12), 1'b1, 1'b0);
        chk("t6_haz_rdy", 32'(ready), 32'd0);
        step(r_type(7'h00, 5'd0, 5'd11, 3'd0, 5'd12), 1'b1, 1'b1);
        chk("t6_rst_wb",  32'(wb),    32'd0);
        chk("t6_rst_rdy", 32'(ready), 32'd1);
        step(32'd0, 1'b0, 1'b1);
        chk("t6_fwd_a", op_a,      32'd7);
        chk("t6_dest2", 32'(dest), 32'd12);

        // randomized traffic; instruction held until accepted
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (m_halt) rstn = ($urandom % 4 != 0);
            else        rstn = ($urandom % 250 != 0);
            if (!valid || m_acc) begin
                valid = ($urandom % 5 != 0);
                instr = rand_instr();
            end
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
